sparse_fiber_arbiter: RTL and testbench

Shares one downstream sparse-stream consumer (an intersect or union unit input) between two upstream 17-bit ready/valid coordinate streams. Grants are fiber-granular: once a requester is granted, its tokens pass uninterrupted until a stop token of the configured level or a done token, so the consumer never sees interleaved fibers. Arbitration is round-robin. The output is registered, and every output token carries the identity of its source requester.

---
 rtl/sparse_arb_pkg.sv | 28 ++
 rtl/sparse_out_reg.sv | 46 ++++
 rtl/sparse_fiber_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sparse_fiber_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_arb_pkg.sv
// Shared types and token classifiers for the sparse fiber arbiter.
// Used by sparse_fiber_arbiter and sparse_out_reg.
package sparse_arb_pkg;

  localparam int TOKEN_W = 17;
  localparam logic [TOKEN_W-1:0] DONE_TOKEN = 17'h10100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_DONE = 2'd3
  } arb_state_t;

  function automatic logic is_done(input logic [TOKEN_W-1:0] token);
    return token == DONE_TOKEN;
  endfunction

  // Stop tokens use the control bit with sub-type bits [9:8] clear.
  function automatic logic is_stop(input logic [TOKEN_W-1:0] token);
    return token[16] && (token[9:8] == 2'b00);
  endfunction

  function automatic logic [7:0] stop_level(input logic [TOKEN_W-1:0] token);
    return token[7:0];
  endfunction

endpackage

// File: rtl/sparse_out_reg.sv
// Single-entry registered output stage carrying a token and its source index.
// Accepts a new entry whenever it is empty or the consumer is taking the current one.
module sparse_out_reg
  import sparse_arb_pkg::*;
#(
  parameter int DATA_W = TOKEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_src,
  input  logic              out_ready,
  output logic              accept,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              out_valid
);

  logic valid_q;

  assign accept    = clk_en && tile_en && (!valid_q || out_ready);
  assign out_valid = valid_q && tile_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      out_data <= '0;
      out_src  <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= load_valid;
        if (load_valid) begin
          out_data <= load_data;
          out_src  <= load_src;
        end
      end
    end
  end

endmodule

// File: rtl/sparse_fiber_arbiter.sv
// Fiber-granular round-robin arbiter sharing one sparse-stream consumer between two requesters.
// Optional performance counters are built when SPARSE_ARB_PERF_EN is defined.
module sparse_fiber_arbiter
  import sparse_arb_pkg::*;
#(
  parameter int DATA_W = 17
`ifdef SPARSE_ARB_PERF_EN
  , parameter int CTR_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic [7:0]        cfg_switch_level,
  input  logic [DATA_W-1:0] in_data_0,
  input  logic              in_valid_0,
  output logic              in_ready_0,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic              in_valid_1,
  output logic              in_ready_1,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              all_done,
  output logic [1:0]        dbg_state,
  output logic              dbg_rr_last
`ifdef SPARSE_ARB_PERF_EN
  , output logic [CTR_W-1:0] perf_grant_cyc_0
  , output logic [CTR_W-1:0] perf_grant_cyc_1
  , output logic [CTR_W-1:0] perf_stall_cyc
`endif
);

  // Handshake: a token moves on any edge where valid and ready are both 1
  // (in_valid_x/in_ready_x upstream, out_valid/out_ready downstream); ready
  // never depends on valid, and valid holds its token until it is taken.

  arb_state_t        state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [1:0]        retired_q, retired_d;
  logic              accept;
  logic              xfer;
  logic [DATA_W-1:0] sel_data;
  logic              sel_src;
  logic              cand0, cand1;

  assign cand0 = in_valid_0 && !retired_q[0];
  assign cand1 = in_valid_1 && !retired_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_last_q <= 1'b1;
      retired_q <= 2'b00;
    end else if (clk_en) begin
      if (flush) begin
        state_q   <= ST_IDLE;
        retired_q <= 2'b00;
      end else begin
        state_q   <= state_d;
        rr_last_q <= rr_last_d;
        retired_q <= retired_d;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    retired_d  = retired_q;
    in_ready_0 = 1'b0;
    in_ready_1 = 1'b0;
    xfer       = 1'b0;
    sel_data   = '0;
    sel_src    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // With both requesting, the one not served last wins.
        if (tile_en) begin
          if (cand0 && (!cand1 || rr_last_q)) begin
            state_d   = ST_GNT0;
            rr_last_d = 1'b0;
          end else if (cand1) begin
            state_d   = ST_GNT1;
            rr_last_d = 1'b1;
          end
        end
      end
      ST_GNT0: begin
        in_ready_0 = accept;
        sel_data   = in_data_0;
        sel_src    = 1'b0;
        xfer       = in_valid_0 && accept;
        if (xfer) begin
          if (is_done(in_data_0)) begin
            retired_d[0] = 1'b1;
            state_d      = retired_q[1] ? ST_DONE : ST_IDLE;
          end else if (is_stop(in_data_0) && (stop_level(in_data_0) >= cfg_switch_level)) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GNT1: begin
        in_ready_1 = accept;
        sel_data   = in_data_1;
        sel_src    = 1'b1;
        xfer       = in_valid_1 && accept;
        if (xfer) begin
          if (is_done(in_data_1)) begin
            retired_d[1] = 1'b1;
            state_d      = retired_q[0] ? ST_DONE : ST_IDLE;
          end else if (is_stop(in_data_1) && (stop_level(in_data_1) >= cfg_switch_level)) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  sparse_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .flush      (flush),
    .tile_en    (tile_en),
    .load_valid (xfer),
    .load_data  (sel_data),
    .load_src   (sel_src),
    .out_ready  (out_ready),
    .accept     (accept),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_valid  (out_valid)
  );

  assign all_done    = (state_q == ST_DONE);
  assign dbg_state   = state_q;
  assign dbg_rr_last = rr_last_q;

`ifdef SPARSE_ARB_PERF_EN
  localparam logic [CTR_W-1:0] CTR_ONE = {{(CTR_W-1){1'b0}}, 1'b1};

  // Saturating counters; they freeze at all ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grant_cyc_0 <= '0;
      perf_grant_cyc_1 <= '0;
      perf_stall_cyc   <= '0;
    end else if (clk_en) begin
      if (flush) begin
        perf_grant_cyc_0 <= '0;
        perf_grant_cyc_1 <= '0;
        perf_stall_cyc   <= '0;
      end else begin
        if ((state_q == ST_GNT0) && !(&perf_grant_cyc_0))
          perf_grant_cyc_0 <= perf_grant_cyc_0 + CTR_ONE;
        if ((state_q == ST_GNT1) && !(&perf_grant_cyc_1))
          perf_grant_cyc_1 <= perf_grant_cyc_1 + CTR_ONE;
        if (out_valid && !out_ready && !(&perf_stall_cyc))
          perf_stall_cyc <= perf_stall_cyc + CTR_ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sparse_fiber_arbiter.sv
// Directed scoreboard bench for sparse_fiber_arbiter: stimulus pushes expected
// {src, token} entries, a monitor pops and compares on every output transfer.
module tb_sparse_fiber_arbiter;
  import sparse_arb_pkg::*;

  logic        clk, rst, clk_en, flush, tile_en;
  logic [7:0]  cfg_switch_level;
  logic [16:0] in_data_0, in_data_1;
  logic        in_valid_0, in_valid_1, in_ready_0, in_ready_1;
  logic [16:0] out_data;
  logic        out_src, out_valid, out_ready, all_done;
  logic [1:0]  dbg_state;
  logic        dbg_rr_last;
`ifdef SPARSE_ARB_PERF_EN
  logic [31:0] perf_grant_cyc_0, perf_grant_cyc_1, perf_stall_cyc;
`endif

  sparse_fiber_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .clk_en           (clk_en),
    .flush            (flush),
    .tile_en          (tile_en),
    .cfg_switch_level (cfg_switch_level),
    .in_data_0        (in_data_0),
    .in_valid_0       (in_valid_0),
    .in_ready_0       (in_ready_0),
    .in_data_1        (in_data_1),
    .in_valid_1       (in_valid_1),
    .in_ready_1       (in_ready_1),
    .out_data         (out_data),
    .out_src          (out_src),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .all_done         (all_done),
    .dbg_state        (dbg_state),
    .dbg_rr_last      (dbg_rr_last)
`ifdef SPARSE_ARB_PERF_EN
    , .perf_grant_cyc_0 (perf_grant_cyc_0)
    , .perf_grant_cyc_1 (perf_grant_cyc_1)
    , .perf_stall_cyc   (perf_stall_cyc)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [17:0] exp_q[$];
  logic [16:0] q0[$], q1[$];
  int          pop_cyc[$];
  int          checks = 0, errors = 0;
  int          pop_cnt = 0, fired0_cnt = 0, fired1_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_tok(input logic src, input logic [16:0] tok);
    exp_q.push_back({src, tok});
  endtask

  // which: 0 = output pops, 1 = req0 transfers, 2 = req1 transfers
  task automatic wait_for(input int which, input int n, input string name);
    int seen;
    checks++;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      seen = (which == 0) ? pop_cnt : (which == 1) ? fired0_cnt : fired1_cnt;
      if (seen >= n) return;
    end
    errors++;
    $display("FAIL %s: timeout waiting for count %0d", name, n);
  endtask

  task automatic pulse_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  // ---------------- drivers ----------------
  initial begin : drv0
    logic f0;
    f0 = 1'b0; in_valid_0 = 1'b0; in_data_0 = '0;
    forever begin
      @(negedge clk);
      if (f0 && q0.size() > 0) q0.delete(0);
      in_valid_0 = (q0.size() > 0);
      in_data_0  = (q0.size() > 0) ? q0[0] : '0;
      #4;
      f0 = in_valid_0 && in_ready_0;
      if (f0) fired0_cnt++;
    end
  end

  initial begin : drv1
    logic f1;
    f1 = 1'b0; in_valid_1 = 1'b0; in_data_1 = '0;
    forever begin
      @(negedge clk);
      if (f1 && q1.size() > 0) q1.delete(0);
      in_valid_1 = (q1.size() > 0);
      in_data_1  = (q1.size() > 0) ? q1[0] : '0;
      #4;
      f1 = in_valid_1 && in_ready_1;
      if (f1) fired1_cnt++;
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [17:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        pop_cnt++;
        pop_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_token: unexpected src=%0d data=%05h", out_src, out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_src, out_data} !== e) begin
            errors++;
            $display("FAIL out_token: got src=%0d data=%05h expected src=%0d data=%05h",
                     out_src, out_data, e[17], e[16:0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : stim
    int b, b0, b1;
    rst = 1'b1; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1;
    cfg_switch_level = 8'd0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    check("rst_all_done", all_done, 0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_rr_last", dbg_rr_last, 1);
    check("rst_in_ready", {in_ready_1, in_ready_0}, 0);
    @(negedge clk); rst = 1'b0;

    // Contention: fibers alternate 0,1,0,1 with one bubble between them.
    @(negedge clk);
    expect_tok(0, 17'h000A1); expect_tok(0, 17'h10000);
    expect_tok(1, 17'h000B1); expect_tok(1, 17'h10000);
    expect_tok(0, 17'h000A2); expect_tok(0, 17'h10000);
    expect_tok(1, 17'h000B2); expect_tok(1, 17'h10000);
    b = pop_cyc.size();
    q0 = '{17'h000A1, 17'h10000, 17'h000A2, 17'h10000};
    q1 = '{17'h000B1, 17'h10000, 17'h000B2, 17'h10000};
    wait_for(0, pop_cnt + 8, "contention_pops");
    if (pop_cyc.size() >= b + 3) begin
      check("contention_b2b", pop_cyc[b+1] - pop_cyc[b], 1);
      check("contention_bubble", pop_cyc[b+2] - pop_cyc[b+1], 2);
    end
    #1 check("contention_rr_last", dbg_rr_last, 1);

    // tile_en=0 gates the grant; then single fiber with a bubble before done.
    @(negedge clk); tile_en = 1'b0;
    expect_tok(0, 17'h00001); expect_tok(0, 17'h00003);
    expect_tok(0, 17'h10000); expect_tok(0, 17'h10100);
    q0 = '{17'h00001, 17'h00003, 17'h10000, 17'h10100};
    repeat (3) @(negedge clk);
    #1;
    check("tile_off_in_ready", in_ready_0, 0);
    check("tile_off_out_valid", out_valid, 0);
    check("tile_off_state", dbg_state, ST_IDLE);
    b = pop_cyc.size();
    tile_en = 1'b1;
    wait_for(0, pop_cnt + 4, "single_pops");
    if (pop_cyc.size() >= b + 4) begin
      check("single_b2b", pop_cyc[b+2] - pop_cyc[b+1], 1);
      check("single_bubble", pop_cyc[b+3] - pop_cyc[b+2], 2);
    end
    pulse_flush();

    // Switch level 1: req0 holds through the level-0 stop.
    cfg_switch_level = 8'd1;
    expect_tok(0, 17'h00002); expect_tok(0, 17'h10000);
    expect_tok(0, 17'h00005); expect_tok(0, 17'h10001);
    expect_tok(1, 17'h00051); expect_tok(1, 17'h10001);
    b0 = fired0_cnt;
    q0 = '{17'h00002, 17'h10000, 17'h00005, 17'h10001};
    wait_for(1, b0 + 1, "switch_first_xfer");
    q1 = '{17'h00051, 17'h10001};
    wait_for(0, pop_cnt + 6, "switch_pops");
    @(negedge clk); cfg_switch_level = 8'd0;

    // Backpressure: five stalled cycles mid-fiber.
    pulse_flush();
    expect_tok(0, 17'h00041); expect_tok(0, 17'h00042); expect_tok(0, 17'h00043);
    expect_tok(0, 17'h00044); expect_tok(0, 17'h10000);
    b = pop_cnt;
    q0 = '{17'h00041, 17'h00042, 17'h00043, 17'h00044, 17'h10000};
    wait_for(0, b + 1, "bp_first_pop");
    @(negedge clk); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold_data", out_data, 17'h00042);
      check("bp_hold_valid", out_valid, 1);
      check("bp_in_ready", in_ready_0, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_for(0, b + 5, "bp_pops");
`ifdef SPARSE_ARB_PERF_EN
    #1 check("bp_perf_stall", perf_stall_cyc, 5);
`endif

    // Completion: req1 wins (rr_last=0), then req0; DONE holds until flush.
    @(negedge clk);
    expect_tok(1, 17'h10100); expect_tok(0, 17'h10100);
    b0 = fired0_cnt; b1 = fired1_cnt;
    q0 = '{17'h10100};
    q1 = '{17'h10100};
    wait_for(2, b1 + 1, "done1_xfer");
    #1 check("done_after_first", all_done, 0);
    wait_for(1, b0 + 1, "done0_xfer");
    #1;
    check("all_done_set", all_done, 1);
    check("done_state", dbg_state, ST_DONE);
    q0.push_back(17'h00061);
    repeat (3) @(negedge clk);
    #1;
    check("done_in_ready", {in_ready_1, in_ready_0}, 0);
    check("done_hold", all_done, 1);
    q0.delete();
    pulse_flush();
    #1;
    check("flush_all_done", all_done, 0);
    check("flush_state", dbg_state, ST_IDLE);

    // Flush coincident with the transfer of 0x32: that token must vanish.
    expect_tok(0, 17'h00031); expect_tok(0, 17'h10000);
    b0 = fired0_cnt; b = pop_cnt;
    q0 = '{17'h00031, 17'h00032, 17'h10000};
    wait_for(1, b0 + 1, "flx_first_xfer");
    pulse_flush();
    wait_for(1, b0 + 3, "flx_all_xfer");
    wait_for(0, b + 2, "flx_pops");
    repeat (3) @(negedge clk);
    check("flx_pop_count", pop_cnt - b, 2);

    // Reset mid-fiber of req1; afterwards rr_last=1 so req0 wins the replay.
    expect_tok(1, 17'h00011);
    b = pop_cnt;
    q1 = '{17'h00011, 17'h00012, 17'h00013, 17'h10000};
    wait_for(0, b + 1, "rst_first_pop");
    @(negedge clk); rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_rr_last", dbg_rr_last, 1);
    q1.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_tok(0, 17'h00021); expect_tok(0, 17'h10000);
    expect_tok(1, 17'h00011); expect_tok(1, 17'h00012);
    expect_tok(1, 17'h00013); expect_tok(1, 17'h10000);
    b = pop_cnt;
    q0 = '{17'h00021, 17'h10000};
    q1 = '{17'h00011, 17'h00012, 17'h00013, 17'h10000};
    wait_for(0, b + 6, "replay_pops");

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
